setpoint_ramp_watchdog: RTL

// Sits between the L/R UART message detectors and the PID_control setpoint input. Converts a

---
 rtl/setpoint_ramp_watchdog.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/setpoint_ramp_watchdog.sv
// Purpose     : slew-limited signed RPM setpoint generator with command-loss watchdog, one per traction side.
// Latency     : setpoint/at_target update on the edge after a tick; target/state on the edge after cmd_valid.
// Backpressure: none; tick and cmd_valid are single-cycle strobes that are always accepted.
//
// Ports
//   FPGA_CLK1_50  in   1   system clock, rising edge
//   RESET_N       in   1   asynchronous active-low reset
//   tick          in   1   control-tick strobe (every 5 ms)
//   cmd_valid     in   1   strobe: cmd_rpm/cmd_dir carry a new command
//   cmd_rpm       in   8   unsigned command magnitude, RPM
//   cmd_dir       in   2   01 = forward, 11 = reverse, 00/10 = stop
//   setpoint      out  16  signed RPM setpoint (two's complement)
//   at_target     out  1   setpoint equals the current target
//   timeout       out  1   high while in FAILSAFE
//   state_o       out  2   00 = IDLE, 01 = RUN, 10 = FAILSAFE

module setpoint_ramp_watchdog #(
    parameter int STEP          = 2,    // max setpoint change per tick, RPM (1..255)
    parameter int MAX_RPM       = 200,  // command magnitude limit, RPM (0..255)
    parameter int TIMEOUT_TICKS = 100   // silent ticks before failsafe (>= 1)
) (
    input  logic        FPGA_CLK1_50,
    input  logic        RESET_N,
    input  logic        tick,
    input  logic        cmd_valid,
    input  logic [7:0]  cmd_rpm,
    input  logic [1:0]  cmd_dir,
    output logic [15:0] setpoint,
    output logic        at_target,
    output logic        timeout,
    output logic [1:0]  state_o
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    // Counter wide enough to hold TIMEOUT_TICKS-1 for any legal value.
    localparam int WD_W = (TIMEOUT_TICKS < 2) ? 1 : $clog2(TIMEOUT_TICKS);

    localparam logic [WD_W-1:0]    WD_LAST = WD_W'(TIMEOUT_TICKS - 1);
    localparam logic [7:0]         MAG_MAX = 8'(MAX_RPM);
    localparam logic signed [16:0] STEP_X  = 17'(STEP);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_RUN      = 2'b01,
        ST_FAILSAFE = 2'b10
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t             state_q,  state_d;
    logic signed [15:0] target_q, target_d;
    logic signed [15:0] sp_q,     sp_d;
    logic [WD_W-1:0]    wd_q,     wd_d;
    logic               at_tgt_q, at_tgt_d;

    // ------------------------------------------------------------------
    // Command decode: saturate magnitude, apply direction sign.
    // ------------------------------------------------------------------
    logic [7:0]         cmd_mag;
    logic signed [15:0] cmd_tgt;

    always_comb begin
        cmd_mag = (cmd_rpm > MAG_MAX) ? MAG_MAX : cmd_rpm;
        cmd_tgt = '0;
        unique case (cmd_dir)
            2'b01:   cmd_tgt = $signed({8'd0, cmd_mag});
            2'b11:   cmd_tgt = 16'sd0 - $signed({8'd0, cmd_mag});
            default: cmd_tgt = '0;   // 00 = stop, 10 = illegal, treated as stop
        endcase
    end

    // ------------------------------------------------------------------
    // Ramp step. A command arriving in the tick cycle steers the step
    // toward the new target; otherwise the registered target is used.
    // On failsafe entry the registered (old) target is still used for
    // that one step; the forced zero target takes effect from the next
    // tick onward.
    // ------------------------------------------------------------------
    logic signed [15:0] ramp_tgt;
    logic signed [16:0] sp_x, tg_x, up_x, dn_x, ramp_x;

    always_comb begin
        ramp_tgt = cmd_valid ? cmd_tgt : target_q;
        sp_x     = {sp_q[15], sp_q};
        tg_x     = {ramp_tgt[15], ramp_tgt};
        up_x     = sp_x + STEP_X;
        dn_x     = sp_x - STEP_X;
        ramp_x   = sp_x;
        if (sp_x < tg_x) begin
            ramp_x = (up_x > tg_x) ? tg_x : up_x;   // clamp: never overshoot
        end else if (sp_x > tg_x) begin
            ramp_x = (dn_x < tg_x) ? tg_x : dn_x;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        sp_d     = sp_q;
        wd_d     = wd_q;
        at_tgt_d = at_tgt_q;

        unique case (state_q)
            ST_IDLE: begin
                wd_d = '0;
                if (cmd_valid) begin
                    state_d  = ST_RUN;
                    target_d = cmd_tgt;
                end
            end

            ST_RUN: begin
                if (cmd_valid) begin
                    // Command wins over a coincident tick: no failsafe entry.
                    target_d = cmd_tgt;
                    wd_d     = '0;
                end else if (tick) begin
                    if (wd_q == WD_LAST) begin
                        state_d  = ST_FAILSAFE;
                        target_d = '0;
                        wd_d     = '0;
                    end else if (wd_q < WD_LAST) begin
                        wd_d = wd_q + 1'b1;   // saturating, never wraps
                    end
                end
            end

            ST_FAILSAFE: begin
                wd_d = '0;
                if (cmd_valid) begin
                    state_d  = ST_RUN;
                    target_d = cmd_tgt;
                end
            end

            default: begin
                state_d  = ST_IDLE;
                target_d = '0;
                wd_d     = '0;
            end
        endcase

        // Setpoint only moves on ticks outside IDLE.
        if (tick && (state_q == ST_RUN || state_q == ST_FAILSAFE)) begin
            sp_d = 16'(ramp_x);
        end

        // Registered from next-cycle values so it lines up with setpoint.
        at_tgt_d = (sp_d == target_d);
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge FPGA_CLK1_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q  <= ST_IDLE;
            target_q <= '0;
            sp_q     <= '0;
            wd_q     <= '0;
            at_tgt_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            sp_q     <= sp_d;
            wd_q     <= wd_d;
            at_tgt_q <= at_tgt_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign setpoint  = sp_q;
    assign at_target = at_tgt_q;
    assign timeout   = (state_q == ST_FAILSAFE);
    assign state_o   = state_q;

endmodule
